// File: rtl/cpu_defs_pkg.sv
// Shared CPU control definitions: opcode constants, instruction-word field
// positions and the sequencer state encoding.
package cpu_defs_pkg;

    // Opcodes the logical-instruction sequencer knows how to execute
    localparam logic [4:0] OPC_AND = 5'b00101;
    localparam logic [4:0] OPC_OR  = 5'b00110;

    // Instruction-word field positions (LSB of each field)
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    // Sequencer phases: DECODE followed by the three datapath steps
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_T3     = 3'd2,
        ST_T4     = 3'd3,
        ST_T5     = 3'd4
    } seq_state_t;

    // True when the opcode is one this sequencer can carry out
    function automatic logic is_legal_op(input logic [4:0] opc);
        return (opc == OPC_AND) || (opc == OPC_OR);
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Per-phase step timer: reloaded on every phase entry, counts down and
// flags the final cycle of the phase so capture strobes land there.
module seq_step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    output logic last
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on phase entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for register-to-register logical instructions (AND, OR).
// Walks the datapath through Rb->Y, Rc+ALU->Z, Zlo->Ra, with every phase
// stretched to STEP_CYCLES cycles. Optional feature macro:
// SEQ_R0_WRITE_GUARD_EN makes R0 read-only by suppressing its write strobe.
module alu_op_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int REG_IDX_W   = 4,
    parameter int STEP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [31:0]          ir,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [REG_IDX_W-1:0] reg_sel,
    output logic                 reg_out,
    output logic                 reg_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 zlo_out,
    output logic                 AND,
    output logic                 OR
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [31:0] ir_q;
    logic [31:0] ir_d;
    logic        stepLoad;
    logic        stepLast;

    logic [4:0]           opcode;
    logic [REG_IDX_W-1:0] raIdx;
    logic [REG_IDX_W-1:0] rbIdx;
    logic [REG_IDX_W-1:0] rcIdx;
    logic                 unused_ir_low;

    assign opcode        = ir_q[OPC_MSB:OPC_LSB];
    assign raIdx         = ir_q[RA_LSB +: REG_IDX_W];
    assign rbIdx         = ir_q[RB_LSB +: REG_IDX_W];
    assign rcIdx         = ir_q[RC_LSB +: REG_IDX_W];
    assign unused_ir_low = ^ir_q[RC_LSB-1:0];

    seq_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clock(clock),
        .clear(clear),
        .load (stepLoad),
        .last (stepLast)
    );

    // State and captured instruction; clear wins over everything
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and Moore-decoded control strobes
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        stepLoad = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        reg_sel  = '0;
        reg_out  = 1'b0;
        reg_in   = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        AND      = 1'b0;
        OR       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ir_d    = ir;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                busy = 1'b1;
                if (is_legal_op(opcode)) begin
                    stepLoad = 1'b1;
                    state_d  = ST_T3;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_T3: begin
                busy    = 1'b1;
                reg_out = 1'b1;
                reg_sel = rbIdx;
                if (stepLast) begin
                    y_in     = 1'b1;
                    stepLoad = 1'b1;
                    state_d  = ST_T4;
                end
            end
            ST_T4: begin
                busy    = 1'b1;
                reg_out = 1'b1;
                reg_sel = rcIdx;
                AND     = (opcode == OPC_AND);
                OR      = (opcode == OPC_OR);
                if (stepLast) begin
                    z_in     = 1'b1;
                    stepLoad = 1'b1;
                    state_d  = ST_T5;
                end
            end
            ST_T5: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
                reg_sel = raIdx;
                if (stepLast) begin
`ifdef SEQ_R0_WRITE_GUARD_EN
                    reg_in = (raIdx != '0);
`else
                    reg_in = 1'b1;
`endif
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table of instructions run
// back-to-back on a STEP_CYCLES=1 instance, plus hand-written sequences for
// clear, ignored start/ir changes and a STEP_CYCLES=3 instance.
module tb_alu_op_sequencer;

    typedef struct {
        logic [31:0] ir;
        logic        legal;
        logic        isOr;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
    } vec_t;

    logic clock = 1'b0;
    logic clear;
    logic start1, start3;
    logic [31:0] ir1, ir3;

    logic busy1, done1, illegal1, regOut1, regIn1, yIn1, zIn1, zloOut1, and1, or1;
    logic busy3, done3, illegal3, regOut3, regIn3, yIn3, zIn3, zloOut3, and3, or3;
    logic [3:0] regSel1, regSel3;
    logic [13:0] act1, act3;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs[6];

    alu_op_sequencer #(.REG_IDX_W(4), .STEP_CYCLES(1)) dut1 (
        .clock(clock), .clear(clear), .start(start1), .ir(ir1),
        .busy(busy1), .done(done1), .illegal(illegal1), .reg_sel(regSel1),
        .reg_out(regOut1), .reg_in(regIn1), .y_in(yIn1), .z_in(zIn1),
        .zlo_out(zloOut1), .AND(and1), .OR(or1)
    );

    alu_op_sequencer #(.REG_IDX_W(4), .STEP_CYCLES(3)) dut3 (
        .clock(clock), .clear(clear), .start(start3), .ir(ir3),
        .busy(busy3), .done(done3), .illegal(illegal3), .reg_sel(regSel3),
        .reg_out(regOut3), .reg_in(regIn3), .y_in(yIn3), .z_in(zIn3),
        .zlo_out(zloOut3), .AND(and3), .OR(or3)
    );

    assign act1 = {busy1, done1, illegal1, regOut1, regIn1, yIn1, zIn1, zloOut1, and1, or1, regSel1};
    assign act3 = {busy3, done3, illegal3, regOut3, regIn3, yIn3, zIn3, zloOut3, and3, or3, regSel3};

    // Free-running clock, 10 time-unit period
    always #5 clock = ~clock;

    // Pack an expected output vector in the same order as act1/act3
    function automatic logic [13:0] mk(input logic busy, input logic done, input logic ill,
                                       input logic regOut, input logic regIn, input logic yIn,
                                       input logic zIn, input logic zloOut, input logic aluAnd,
                                       input logic aluOr, input logic [3:0] sel);
        return {busy, done, ill, regOut, regIn, yIn, zIn, zloOut, aluAnd, aluOr, sel};
    endfunction

    // Expected write strobe for a destination register
    function automatic logic regInFor(input logic [3:0] ra);
`ifdef SEQ_R0_WRITE_GUARD_EN
        return (ra != 4'd0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start an instruction on dut1 from an IDLE cycle and check its whole trace
    task automatic applyStimulus(input vec_t v, input int idx);
        logic aAnd;
        logic aOr;
        aAnd = v.legal && !v.isOr;
        aOr  = v.legal && v.isOr;
        ir1    = v.ir;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        if (v.legal) begin
            checkOutput($sformatf("vec%0d decode", idx), act1, mk(1,0,0,0,0,0,0,0,0,0,4'd0));
            tick();
            checkOutput($sformatf("vec%0d T3", idx), act1, mk(1,0,0,1,0,1,0,0,0,0,v.rb));
            tick();
            checkOutput($sformatf("vec%0d T4", idx), act1, mk(1,0,0,1,0,0,1,0,aAnd,aOr,v.rc));
            tick();
            checkOutput($sformatf("vec%0d T5", idx), act1, mk(1,1,0,0,regInFor(v.ra),0,0,1,0,0,v.ra));
        end else begin
            checkOutput($sformatf("vec%0d illegal", idx), act1, mk(1,0,1,0,0,0,0,0,0,0,4'd0));
        end
        tick();
        checkOutput($sformatf("vec%0d idle", idx), act1, 14'd0);
    endtask

    initial begin
        vecs[0] = '{32'h29228000, 1'b1, 1'b0, 4'd2, 4'd4, 4'd5};
        vecs[1] = '{{5'b00110, 4'd7, 4'd1, 4'd3, 15'd0}, 1'b1, 1'b1, 4'd7, 4'd1, 4'd3};
        vecs[2] = '{{5'b11111, 4'd3, 4'd3, 4'd3, 15'h7fff}, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3};
        vecs[3] = '{{5'b00101, 4'd0, 4'd9, 4'd15, 15'd0}, 1'b1, 1'b0, 4'd0, 4'd9, 4'd15};
        vecs[4] = '{{5'b00000, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3};
        vecs[5] = '{{5'b00110, 4'd15, 4'd14, 4'd0, 15'h1234}, 1'b1, 1'b1, 4'd15, 4'd14, 4'd0};

        clear  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        ir1    = 32'd0;
        ir3    = 32'd0;
        tick();
        tick();
        checkOutput("reset dut1", act1, 14'd0);
        checkOutput("reset dut3", act3, 14'd0);
        clear = 1'b0;
        tick();
        checkOutput("idle after reset", act1, 14'd0);

        // Table: each instruction starts in the IDLE cycle of the previous one
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // clear in T4 aborts: no reg_in or done afterwards
        ir1    = vecs[0].ir;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        checkOutput("clr pre T4", act1, mk(1,0,0,1,0,0,1,0,1,0,4'd5));
        clear = 1'b1;
        tick();
        checkOutput("clr abort", act1, 14'd0);
        clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("clr quiet%0d", c), act1, 14'd0);
        end

        // clear overrides start
        clear  = 1'b1;
        start1 = 1'b1;
        tick();
        checkOutput("clr over start", act1, 14'd0);
        clear  = 1'b0;
        start1 = 1'b0;
        tick();
        checkOutput("clr over start idle", act1, 14'd0);

        // start and ir changes while busy are ignored
        ir1    = vecs[1].ir;
        start1 = 1'b1;
        tick();
        ir1 = vecs[2].ir;
        checkOutput("ign decode", act1, mk(1,0,0,0,0,0,0,0,0,0,4'd0));
        tick();
        ir1 = vecs[0].ir;
        checkOutput("ign T3", act1, mk(1,0,0,1,0,1,0,0,0,0,4'd1));
        tick();
        checkOutput("ign T4", act1, mk(1,0,0,1,0,0,1,0,0,1,4'd3));
        start1 = 1'b0;
        tick();
        checkOutput("ign T5", act1, mk(1,1,0,0,1,0,0,1,0,0,4'd7));
        tick();
        checkOutput("ign idle", act1, 14'd0);

        // STEP_CYCLES=3: each phase held three cycles, strobes on the third
        ir3    = vecs[0].ir;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            logic [13:0] exp;
            logic        lastC;
            int          ph;
            if (c == 1) begin
                exp = mk(1,0,0,0,0,0,0,0,0,0,4'd0);
            end else if (c <= 10) begin
                ph    = (c - 2) / 3;
                lastC = ((c - 2) % 3) == 2;
                if (ph == 0)
                    exp = mk(1,0,0,1,0,lastC,0,0,0,0,4'd4);
                else if (ph == 1)
                    exp = mk(1,0,0,1,0,0,lastC,0,1,0,4'd5);
                else
                    exp = mk(1,lastC,0,0,lastC,0,0,1,0,0,4'd2);
            end else begin
                exp = 14'd0;
            end
            checkOutput($sformatf("step3 c%0d", c), act3, exp);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
